// File: rtl/register.sv
// Clock-enabled D register with asynchronous active-low clear.
// Q comes straight from the flops; no combinational path from D.
module register #(
  parameter int         N       = 7,
  parameter logic [N:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [N:0] D,
  output logic [N:0] Q
);

  logic [N:0] q_d;
  logic [N:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_register.sv
// Bench for register: directed load/hold/reset checks plus random
// traffic and counter/FSM feedback rings against a behavioural model.
module tb_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       en8, en6, en6z, en1;
  logic [7:0] d8, q8;
  logic [5:0] d6, q6;
  logic [5:0] d6z, q6z;
  logic [0:0] d1, q1;
  logic [7:0] d_cnt, q_cnt;
  logic [5:0] d_fsm, q_fsm;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  // model state
  logic [7:0] m8;
  logic [5:0] m6, m6z;
  logic [0:0] m1;
  int         k;

  always #5 clk = ~clk;

  register u8 (
    .clk(clk), .rst(rst), .en(en8), .D(d8), .Q(q8)
  );
  register #(.N(5), .RST_VAL(6'h15)) u6 (
    .clk(clk), .rst(rst), .en(en6), .D(d6), .Q(q6)
  );
  register #(.N(5)) u6z (
    .clk(clk), .rst(rst), .en(en6z), .D(d6z), .Q(q6z)
  );
  register #(.N(0)) u1 (
    .clk(clk), .rst(rst), .en(en1), .D(d1), .Q(q1)
  );
  register #(.N(7)) ucnt (
    .clk(clk), .rst(rst), .en(1'b1), .D(d_cnt), .Q(q_cnt)
  );
  register #(.N(5)) ufsm (
    .clk(clk), .rst(rst), .en(1'b1), .D(d_fsm), .Q(q_fsm)
  );

  assign d_cnt = q_cnt + 8'd1;
  assign d_fsm = (q_fsm == 6'd19) ? 6'd3 : q_fsm + 6'd1;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fsm_exp(input int kk);
    if (kk < 20) return kk;
    return 3 + ((kk - 20) % 17);
  endfunction

  // Model: async clear, otherwise take D on enabled edges.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m8 = 8'h00; m6 = 6'h15; m6z = 6'h00; m1 = 1'b0; k = 0;
    end else begin
      if (en8)  m8  = d8;
      if (en6)  m6  = d6;
      if (en6z) m6z = d6z;
      if (en1)  m1  = d1;
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("q8", q8, m8);
      chk("q6", {2'b0, q6}, {2'b0, m6});
      chk("q6z", {2'b0, q6z}, {2'b0, m6z});
      chk("q1", {7'b0, q1}, {7'b0, m1});
      chk("cnt", q_cnt, 8'(k % 256));
      chk("fsm", {2'b0, q_fsm}, 8'(fsm_exp(k)));
      if (k == 20)  chk("fsm_pin20", {2'b0, q_fsm}, 8'h03);
      if (k == 36)  chk("fsm_pin36", {2'b0, q_fsm}, 8'h13);
      if (k == 255) chk("cnt_pin255", q_cnt, 8'hFF);
      if (k == 256) chk("cnt_wrap", q_cnt, 8'h00);
    end
  end

  task automatic randomize_inputs();
    en8  = 1'($urandom); d8  = 8'($urandom);
    en6  = 1'($urandom); d6  = 6'($urandom);
    en6z = 1'($urandom); d6z = 6'($urandom);
    en1  = 1'($urandom); d1  = 1'($urandom);
  endtask

  task automatic load8(input logic [7:0] v);
    d8 = v;
    @(posedge clk); #1;
    chk("load8", q8, v);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    en8 = 1'b1; d8 = 8'h77;
    en6 = 1'b1; d6 = 6'h2A;
    en6z = 1'b1; d6z = 6'h2A;
    en1 = 1'b1; d1 = 1'b1;
    #1 run_cmp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold6z", {2'b0, q6z}, 8'h00);
    chk("rst_val6", {2'b0, q6}, 8'h15);
    chk("rst_hold8", q8, 8'h00);
    chk("rst_hold1", {7'b0, q1}, 8'h00);
    #1;
    rst = 1'b1;
    en6 = 1'b0; en6z = 1'b0; en1 = 1'b0;
    en8 = 1'b1;
    load8(8'h00);
    load8(8'h01);
    load8(8'hFF);
    load8(8'hA5);
    load8(8'h3C);
    en8 = 1'b0; d8 = 8'hC3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold8", q8, 8'h3C);
      #1;
    end
    en8 = 1'b1;
    @(posedge clk); #1;
    chk("reload8", q8, 8'hC3);
    #1;
    repeat (290) begin
      randomize_inputs();
      @(posedge clk); #2;
    end
    // clear between edges: Q must drop before the next edge
    en8 = 1'b1; d8 = 8'h5A;
    en6 = 1'b1; d6 = 6'h3F;
    rst = 1'b0;
    #1;
    chk("mid_rst8", q8, 8'h00);
    chk("mid_rst6", {2'b0, q6}, 8'h15);
    chk("mid_rst_cnt", q_cnt, 8'h00);
    chk("mid_rst_fsm", {2'b0, q_fsm}, 8'h00);
    @(posedge clk); #1;
    chk("rst_wins8", q8, 8'h00);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (60) begin
      randomize_inputs();
      @(posedge clk); #2;
    end
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
